// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control block: ALUOp, funct, ALUControl and the
// mult/div sequencer states.
package alu_ctrl_pkg;

    typedef logic [1:0] aluop_t;
    typedef logic [5:0] func_t;
    typedef logic [2:0] aluctl_t;

    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_RTYPE = 2'b10;
    localparam aluop_t ALUOP_OR    = 2'b11;

    localparam func_t F_ADD   = 6'b100000;
    localparam func_t F_SUB   = 6'b100010;
    localparam func_t F_AND   = 6'b100100;
    localparam func_t F_OR    = 6'b100101;
    localparam func_t F_SLT   = 6'b101010;
    localparam func_t F_MULT  = 6'b011000;
    localparam func_t F_MULTU = 6'b011001;
    localparam func_t F_DIV   = 6'b011010;
    localparam func_t F_DIVU  = 6'b011011;
    localparam func_t F_MFHI  = 6'b010000;
    localparam func_t F_MTHI  = 6'b010001;
    localparam func_t F_MFLO  = 6'b010010;
    localparam func_t F_MTLO  = 6'b010011;

    localparam aluctl_t CTL_AND = 3'b000;
    localparam aluctl_t CTL_OR  = 3'b001;
    localparam aluctl_t CTL_ADD = 3'b010;
    localparam aluctl_t CTL_SUB = 3'b110;
    localparam aluctl_t CTL_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // MULT/MULTU/DIV/DIVU share the 0110xx encoding; bit0 = unsigned, bit1 = divide.
    function automatic logic is_iter_func(input func_t f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic is_md_func(input func_t f);
        return (f[5:2] == 4'b0110) || (f[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Bundle between the main control FSM / register file and the ALU control
// plus mult/div unit.
interface alu_ctrl_md_if #(
    parameter int DATA_W = 32
) ();
    import alu_ctrl_pkg::*;

    logic              start;
    aluop_t            alu_op;
    func_t             func;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    aluctl_t           alu_control;
    logic              illegal;
    logic              md_busy;
    logic              md_done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] mf_result;
    logic              mf_valid;

    modport master (
        output start, alu_op, func, src_a, src_b,
        input  alu_control, illegal, md_busy, md_done, hi, lo, mf_result, mf_valid
    );

    modport slave (
        input  start, alu_op, func, src_a, src_b,
        output alu_control, illegal, md_busy, md_done, hi, lo, mf_result, mf_valid
    );

endinterface

// File: rtl/alu_ctrl_md_iter_core.sv
// Shared shift/accumulate datapath for iterative unsigned multiply (shift-add)
// and restoring divide, with sign fix-up applied to the final step's result.
module md_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic sgn);
        return (sgn && (v < 0)) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate_wide_if(input logic [2*DATA_W-1:0] v,
                                                           input logic en);
        return en ? -v : v;
    endfunction

    // acc: product upper half / partial remainder; shr: multiplier / quotient.
    logic [DATA_W-1:0] acc, shr, opnd;
    logic              div_mode, neg_q, neg_r, div_zero;

    logic [DATA_W:0]     add_sum, trial;
    logic [DATA_W-1:0]   diff, acc_nxt, shr_nxt, mag_a, mag_b;
    logic                fits;
    logic [2*DATA_W-1:0] prod_fix;

    assign mag_a = magnitude(op_a, is_signed);
    assign mag_b = magnitude(op_b, is_signed);

    always_comb begin
        add_sum = {1'b0, acc} + (shr[0] ? {1'b0, opnd} : '0);
        trial   = {acc, shr[DATA_W-1]};
        fits    = (trial >= {1'b0, opnd});
        // When the subtract is taken the difference is below opnd, so the low bits suffice.
        diff    = trial[DATA_W-1:0] - opnd;
        if (div_mode) begin
            acc_nxt = fits ? diff : trial[DATA_W-1:0];
            shr_nxt = {shr[DATA_W-2:0], fits};
        end else begin
            acc_nxt = add_sum[DATA_W:1];
            shr_nxt = {add_sum[0], shr[DATA_W-1:1]};
        end
    end

    always_comb begin
        prod_fix = negate_wide_if({acc_nxt, shr_nxt}, neg_q);
        if (div_mode) begin
            res_lo = div_zero ? '1 : negate_if(shr_nxt, neg_q);
            res_hi = negate_if(acc_nxt, neg_r);
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            shr      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            shr      <= is_div ? mag_a : mag_b;
            opnd     <= is_div ? mag_b : mag_a;
            div_mode <= is_div;
            neg_q    <= is_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_r    <= is_signed && op_a[DATA_W-1];
            div_zero <= is_div && (op_b == '0);
        end else if (step) begin
            acc <= acc_nxt;
            shr <= shr_nxt;
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// MIPS ALU control decode plus iterative mult/div sequencer with HI/LO,
// exposing a busy/done handshake for the main control FSM.
module alu_ctrl_md #(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_ctrl_md_if.slave bus
);
    import alu_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hi_r, lo_r, res_hi, res_lo;
    logic              busy_r, done_r;
    logic              accept, go, mt_hi, mt_lo;

    // MD starts are only honoured in IDLE; busy-time starts are dropped outright.
    assign accept = bus.start && (bus.alu_op == ALUOP_RTYPE) && (state == IDLE);
    assign go     = accept && is_iter_func(bus.func);
    assign mt_hi  = accept && (bus.func == F_MTHI);
    assign mt_lo  = accept && (bus.func == F_MTLO);

    always_comb begin
        bus.alu_control = CTL_AND;
        bus.illegal     = 1'b0;
        case (bus.alu_op)
            ALUOP_ADD: bus.alu_control = CTL_ADD;
            ALUOP_SUB: bus.alu_control = CTL_SUB;
            ALUOP_OR:  bus.alu_control = CTL_OR;
            default: begin
                case (bus.func)
                    F_ADD:   bus.alu_control = CTL_ADD;
                    F_SUB:   bus.alu_control = CTL_SUB;
                    F_AND:   bus.alu_control = CTL_AND;
                    F_OR:    bus.alu_control = CTL_OR;
                    F_SLT:   bus.alu_control = CTL_SLT;
                    default: begin
                        if (is_md_func(bus.func)) begin
                            bus.alu_control = CTL_ADD;
                        end else begin
                            bus.alu_control = CTL_AND;
                            bus.illegal     = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    md_iter_core #(.DATA_W(DATA_W)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (go),
        .step      (state == RUN),
        .is_div    (bus.func[1]),
        .is_signed (~bus.func[0]),
        .op_a      (bus.src_a),
        .op_b      (bus.src_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state  <= RUN;
                        cnt    <= CNT_W'(DATA_W);
                        busy_r <= 1'b1;
                    end else if (mt_hi) begin
                        hi_r <= bus.src_a;
                    end else if (mt_lo) begin
                        lo_r <= bus.src_a;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    // Last step: the core's fixed-up result is committed straight into HI/LO.
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md_busy   = busy_r;
    assign bus.md_done   = done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
    assign bus.mf_result = (bus.func == F_MFHI) ? hi_r : lo_r;
    assign bus.mf_valid  = ~busy_r;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode sweep, mult/div results via a
// reference-model scoreboard, busy-time start rejection, MT/MF, and async reset abort.
module tb_alu_ctrl_md;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_md_if #(.DATA_W(W)) bus ();
    alu_ctrl_md #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned issue_cyc = 0;
    logic [63:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: returns {hi, lo}.
    function automatic logic [63:0] model(input func_t f, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        int     sa, sb_i;
        logic [63:0] r;
        r = '0;
        case (f)
            F_MULT: begin
                pa = $signed(a);
                pb = $signed(b);
                r  = pa * pb;
            end
            F_MULTU: r = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0)                                  r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)      r = {32'h0, 32'h8000_0000};
                else begin
                    sa   = $signed(a);
                    sb_i = $signed(b);
                    r    = {32'(sa % sb_i), 32'(sa / sb_i)};
                end
            end
            F_DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.alu_op = ALUOP_ADD;
        bus.func   = '0;
        bus.src_a  = '0;
        bus.src_b  = '0;
    endtask

    task automatic issue(input func_t f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = ALUOP_RTYPE;
        bus.func   = f;
        bus.src_a  = a;
        bus.src_b  = b;
        sb.push_back(model(f, a, b));
        @(negedge clk);
        issue_cyc = cyc;
        idle_inputs();
        check("busy_rise", 64'(bus.md_busy), 64'd1);
        check("mf_valid_busy", 64'(bus.mf_valid), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        logic        seen;
        int          n;
        logic [63:0] exp;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < W + 8) begin
            if (bus.md_done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_latency"}, seen ? 64'(cyc - issue_cyc) : 64'hDEAD, 64'(W));
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hBAD;
        if (seen) begin
            check({tag, "_busy_in_done"}, 64'(bus.md_busy), 64'd1);
            check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
            check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
            @(negedge clk);
            check({tag, "_done_pulse_end"}, 64'(bus.md_done), 64'd0);
            check({tag, "_busy_end"}, 64'(bus.md_busy), 64'd0);
        end
    endtask

    task automatic decode(input string tag, input aluop_t op, input func_t f,
                          input aluctl_t ctl, input logic ill);
        @(negedge clk);
        bus.alu_op = op;
        bus.func   = f;
        #1;
        check(tag, 64'({bus.alu_control, bus.illegal}), 64'({ctl, ill}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        func_t rf;
        logic [31:0] ra, rb;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.md_busy), 64'd0);
        check("rst_done", 64'(bus.md_done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_mf_valid", 64'(bus.mf_valid), 64'd1);
        rst_n = 1'b1;

        decode("dec_slt", ALUOP_RTYPE, F_SLT, CTL_SLT, 1'b0);
        decode("dec_bad", ALUOP_RTYPE, 6'b000111, CTL_AND, 1'b1);
        decode("dec_or_i", ALUOP_OR, 6'b000111, CTL_OR, 1'b0);
        decode("dec_sub_b", ALUOP_SUB, F_SLT, CTL_SUB, 1'b0);
        decode("dec_lw", ALUOP_ADD, 6'b000000, CTL_ADD, 1'b0);
        decode("dec_and", ALUOP_RTYPE, F_AND, CTL_AND, 1'b0);
        decode("dec_rsub", ALUOP_RTYPE, F_SUB, CTL_SUB, 1'b0);
        decode("dec_mult", ALUOP_RTYPE, F_MULT, CTL_ADD, 1'b0);
        decode("dec_mtlo", ALUOP_RTYPE, F_MTLO, CTL_ADD, 1'b0);

        // Non-MD start has no sequential effect.
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = ALUOP_RTYPE; bus.func = F_ADD; bus.src_a = 32'h55;
        @(negedge clk);
        idle_inputs();
        check("nonmd_start_busy", 64'(bus.md_busy), 64'd0);
        check("nonmd_start_hi", 64'(bus.hi), 64'd0);

        issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult");
        check("mult_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(bus.lo), 64'hFFFF_FFEB);

        issue(F_MULTU, 32'hFFFF_FFFD, 32'd7);
        wait_done("multu");
        check("multu_hi_const", 64'(bus.hi), 64'h6);

        issue(F_DIVU, 32'd100, 32'd7);
        wait_done("divu");
        check("divu_lo_const", 64'(bus.lo), 64'd14);

        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg");

        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min");

        issue(F_DIVU, 32'd5, 32'd0);
        wait_done("divu_zero");

        issue(F_DIV, 32'hFFFF_FFF7, 32'd0);
        wait_done("div_zero_neg");

        // Starts during a running DIV must be ignored.
        issue(F_DIV, 32'd1000, 32'hFFFF_FFFD);
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.alu_op = ALUOP_RTYPE; bus.func = F_MULT;
        bus.src_a = 32'd5; bus.src_b = 32'd6;
        @(negedge clk);
        bus.func = F_MTHI; bus.src_a = 32'd1234;
        @(negedge clk);
        idle_inputs();
        wait_done("div_busy_starts");

        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = ALUOP_RTYPE; bus.func = F_MTHI; bus.src_a = 32'd1234;
        @(negedge clk);
        bus.start = 1'b0; bus.func = F_MFHI; bus.src_a = '0;
        #1;
        check("mthi_hi", 64'(bus.hi), 64'd1234);
        check("mthi_no_busy", 64'(bus.md_busy), 64'd0);
        check("mfhi_result", 64'(bus.mf_result), 64'd1234);
        check("mfhi_valid", 64'(bus.mf_valid), 64'd1);

        @(negedge clk);
        bus.start = 1'b1; bus.func = F_MTLO; bus.src_a = 32'hCAFE_0001;
        @(negedge clk);
        bus.start = 1'b0; bus.func = F_MFLO; bus.src_a = '0;
        #1;
        check("mflo_result", 64'(bus.mf_result), 64'hCAFE_0001);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd1234);

        // Async reset in the middle of a MULT aborts it with no done pulse.
        issue(F_MULT, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.md_busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (bus.md_done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        issue(F_MULT, 32'd123, 32'hFFFF_FE38);
        wait_done("mult_after_rst");

        for (int i = 0; i < 4; i++) begin
            rf = F_MULT | func_t'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            issue(rf, ra, rb);
            wait_done("rand_op");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Next-generation ALU control for the multicycle MIPS core.
- Keeps the ALUOp/func to ALUControl decode and adds a parametrised iterative multiply/divide unit with HI/LO registers.
- Adds a busy/done handshake that the main control FSM stalls on.
- Sits between the main control FSM, the register-file read ports (src_a/src_b) and the writeback mux (mf_result).

Parameters:
- DATA_W, 32, operand/HI/LO width; must be >= 4 and even.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  control FSM issues the current instruction (execute cycle)
- alu_op  in  2  ALUOp from main control
- func  in  6  instruction funct field
- src_a  in  DATA_W  rs operand
- src_b  in  DATA_W  rt operand
- alu_control  out  3  ALU operation select (combinational)
- illegal  out  1  unknown func with alu_op=10 (combinational)
- md_busy  out  1  mult/div in progress; control FSM must stall
- md_done  out  1  one-cycle pulse, HI/LO updated
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- mf_result  out  DATA_W  MFHI/MFLO read data (combinational)
- mf_valid  out  1  mf_result usable (= !md_busy)

Behaviour:
- Decode (combinational):
  - alu_op 00 -> 010 (add); 01 -> 110 (sub); 11 -> 001 (or, ori).
  - alu_op 10: func 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - alu_op 10 with func in the MD set {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO}: alu_control=010, illegal=0.
  - Any other func with alu_op 10: alu_control=000, illegal=1. No X outputs.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN when start & alu_op==10 & func is MULT/MULTU/DIV/DIVU. At that edge: capture operand magnitudes (signed ops take two's-complement abs), capture sign flags, counter=DATA_W.
  - RUN: one radix-2 step per cycle; counter decrements; RUN -> DONE when counter reaches 1 at that edge. RUN lasts exactly DATA_W cycles.
  - DONE: HI/LO hold the final result; md_done=1 for exactly one cycle; next state IDLE.
- Busy and latency:
  - md_busy=1 in RUN and DONE.
  - Start accepted at edge e: md_done high during cycle e+DATA_W+1, and HI/LO hold the new values from that cycle on.
- Multiply: shift-add unsigned over the magnitudes. The 2*DATA_W product is negated if signed and signs differ. HI = upper half, LO = lower half.
- Divide: restoring divide over the magnitudes. LO = quotient, negated if signed and signs differ. HI = remainder, carrying the sign of the dividend.
  - Divide by zero: normal latency; LO = all ones, HI = src_a (raw).
  - Signed MIN/-1: LO = MIN, HI = 0.
- MTHI/MTLO: with start in IDLE, write src_a to hi/lo at that edge. Single cycle, no busy, no done.
- MFHI/MFLO: mf_result = hi (func 010000) else lo. Valid only while mf_valid=1.
- Starts while md_busy=1 (any MD func, including MTHI/MTLO) are ignored with no state change. start with a non-MD func has no sequential effect.
- Reset: async assert at any time, including mid-RUN. Aborts the operation: state=IDLE, hi=lo=0, md_busy=0, md_done=0, counter=0, datapath regs=0. No done pulse follows.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUOp codes;
  - func codes, including the MD set;
  - ALUControl codes (ADD=010, SUB=110, AND=000, OR=001, SLT=111);
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module md_iter_core(DATA_W) holds the shared shift register/accumulator datapath: one shift-add or restore-subtract step per enable, with sign fix-up at DONE. alu_ctrl_md keeps the decode, FSM, counter and HI/LO.

Test Plan (DATA_W=32):
- Decode sweep: alu_op=10, func=101010 -> alu_control=111, illegal=0; func=000111 -> 000, illegal=1; alu_op=11 -> 001; alu_op=01 -> 110.
- MULT a=FFFFFFFD (-3), b=7, start at edge 0 -> md_busy rises, md_done pulse in cycle 33 only; HI=FFFFFFFF, LO=FFFFFFEB. MULTU same operands -> HI=00000006, LO=FFFFFFEB.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=FFFFFFF9 (-7), b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=0.
- DIVU a=5, b=0 -> done at cycle 33, LO=FFFFFFFF, HI=5.
- Second MULT start and an MTHI (src_a=1234) issued at cycle 10 of a running DIV -> both ignored, DIV result intact. Then MTHI 1234 in IDLE -> hi=1234 next cycle, MFHI mf_result=1234, mf_valid=1.
- rst_n pulsed low at cycle 10 of a MULT -> md_busy=0 and hi=lo=0 immediately, no md_done afterwards; a new MULT after reset completes normally.
